// File: rtl/bsg_axil_watchdog_responder.sv
// bsg_axil_watchdog_responder
//   AXI4-Lite subordinate that terminates heartbeat ("ping") writes from a
//   watchdog initiator, counts them, keeps the last ping payload, measures
//   idle time since the last ping and raises a sticky timeout flag.
//
//   Register map (decoded on addr[3:2]):
//     0x0 PING_COUNT  read: ping count; write: ping (count+1, LAST_DATA <= wdata)
//     0x4 LAST_DATA   read-only
//     0x8 IDLE_CYCLES read-only, saturating
//     0xC STATUS      bit0 timeout, write 1 to clear
//
//   Ports:
//     clk_i, reset_i            clock, async active-high reset
//     s_axil_aw*/w*/b*          write channel (joint AW+W single-beat handshake)
//     s_axil_ar*/r*             read channel
//     ping_v_o                  one-cycle pulse per accepted ping
//     timeout_o                 sticky timeout flag
module bsg_axil_watchdog_responder #(
   parameter int timeout_cycles_p  = 50000000,
   parameter int axil_data_width_p = 32,
   parameter int axil_addr_width_p = 28
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
   input  logic [2:0]                     s_axil_awprot_i,
   input  logic                           s_axil_awvalid_i,
   output logic                           s_axil_awready_o,
   input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
   input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
   input  logic                           s_axil_wvalid_i,
   output logic                           s_axil_wready_o,
   output logic [1:0]                     s_axil_bresp_o,
   output logic                           s_axil_bvalid_o,
   input  logic                           s_axil_bready_i,
   input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
   input  logic [2:0]                     s_axil_arprot_i,
   input  logic                           s_axil_arvalid_i,
   output logic                           s_axil_arready_o,
   output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
   output logic [1:0]                     s_axil_rresp_o,
   output logic                           s_axil_rvalid_o,
   input  logic                           s_axil_rready_i,
   output logic                           ping_v_o,
   output logic                           timeout_o
);

   localparam logic [31:0] c_to_m1 = 32'(timeout_cycles_p - 1);

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   w_state_e                       r_wstate;
   r_state_e                       r_rstate;
   logic                           r_bvalid;
   logic                           r_arready;
   logic                           r_rvalid;
   logic [axil_data_width_p-1:0]   r_rdata;
   logic [31:0]                    r_count;
   logic [axil_data_width_p-1:0]   r_last;
   logic [31:0]                    r_idle;
   logic                           r_timeout;
   logic                           r_ping_v;

   logic                           w_wr_fire;
   logic                           w_rd_fire;
   logic                           w_ping;
   logic                           w_clr;
   logic                           w_set;
   logic [axil_data_width_p-1:0]   w_rd_mux;
   logic                           w_unused;

   // AW and W are only taken together, so ready depends on both valids.
   assign w_wr_fire = (r_wstate == W_IDLE) & s_axil_awvalid_i & s_axil_wvalid_i;
   assign w_rd_fire = r_arready & s_axil_arvalid_i;
   assign w_ping    = w_wr_fire & (s_axil_awaddr_i[3:2] == 2'd0);
   assign w_clr     = w_wr_fire & (s_axil_awaddr_i[3:2] == 2'd3) & s_axil_wdata_i[0];
   // Next idle value reaches the bound while counting; kept asserted while the
   // counter stays at/above it so a concurrent clear loses to the set.
   assign w_set     = ~w_ping & (r_idle >= c_to_m1);

   assign w_unused  = ^{s_axil_awprot_i, s_axil_wstrb_i, s_axil_arprot_i,
                        s_axil_awaddr_i[axil_addr_width_p-1:4], s_axil_awaddr_i[1:0],
                        s_axil_araddr_i[axil_addr_width_p-1:4], s_axil_araddr_i[1:0]};

   assign s_axil_awready_o = w_wr_fire;
   assign s_axil_wready_o  = w_wr_fire;
   assign s_axil_bvalid_o  = r_bvalid;
   assign s_axil_bresp_o   = 2'b00;
   assign s_axil_arready_o = r_arready;
   assign s_axil_rvalid_o  = r_rvalid;
   assign s_axil_rdata_o   = r_rdata;
   assign s_axil_rresp_o   = 2'b00;
   assign ping_v_o         = r_ping_v;
   assign timeout_o        = r_timeout;

   // Read mux sees pre-write register values when a write lands the same cycle.
   always_comb begin
      w_rd_mux = '0;
      unique case (s_axil_araddr_i[3:2])
         2'd0: w_rd_mux = r_count;
         2'd1: w_rd_mux = r_last;
         2'd2: w_rd_mux = r_idle;
         2'd3: w_rd_mux = {{(axil_data_width_p-1){1'b0}}, r_timeout};
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wstate <= W_IDLE;
         r_bvalid <= 1'b0;
      end else begin
         unique case (r_wstate)
            W_IDLE: if (w_wr_fire) begin
               r_wstate <= W_RESP;
               r_bvalid <= 1'b1;
            end
            W_RESP: if (s_axil_bready_i) begin
               r_wstate <= W_IDLE;
               r_bvalid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b1;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         unique case (r_rstate)
            R_IDLE: if (w_rd_fire) begin
               r_rstate  <= R_DATA;
               r_arready <= 1'b0;
               r_rvalid  <= 1'b1;
               r_rdata   <= w_rd_mux;
            end
            R_DATA: if (s_axil_rready_i) begin
               r_rstate  <= R_IDLE;
               r_arready <= 1'b1;
               r_rvalid  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_count   <= '0;
         r_last    <= '0;
         r_idle    <= '0;
         r_timeout <= 1'b0;
         r_ping_v  <= 1'b0;
      end else begin
         r_ping_v <= w_ping;
         if (w_ping) begin
            r_count <= r_count + 32'd1;
            r_last  <= s_axil_wdata_i;
            r_idle  <= '0;
         end else if (r_idle != '1) begin
            r_idle  <= r_idle + 32'd1;
         end
         if (w_set)      r_timeout <= 1'b1;
         else if (w_clr) r_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bsg_axil_watchdog_responder.sv
// Self-checking bench for bsg_axil_watchdog_responder with a 100-cycle bound.
// Expected read data is pushed to a scoreboard queue when a read is issued and
// popped when the DUT returns data.
module tb_bsg_axil_watchdog_responder;
   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [27:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        arvalid, arready, rvalid, rready, ping_v, timeout;

   int          n_chk = 0, n_fail = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_count = 0;
   logic [31:0] rd, exp;
   logic        ok, bv, pv;

   bsg_axil_watchdog_responder #(.timeout_cycles_p(TO), .axil_data_width_p(32),
                                 .axil_addr_width_p(28)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot),
      .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
      .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb),
      .s_axil_wvalid_i(wvalid), .s_axil_wready_o(wready),
      .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
      .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot),
      .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
      .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp),
      .s_axil_rvalid_o(rvalid), .s_axil_rready_i(rready),
      .ping_v_o(ping_v), .timeout_o(timeout));

   always #5 clk = ~clk;

   // Drivers: start and return 1 time unit after a rising edge.
   task automatic do_write(input logic [27:0] a, input logic [31:0] d,
                           output logic bv_o, output logic pv_o, output logic ok_o);
      logic acc;
      acc = 1'b0;
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1; acc = awready;
         @(posedge clk); #1;
         if (acc) break;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bv_o = bvalid; pv_o = ping_v; ok_o = acc;
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [27:0] a, output logic [31:0] d, output logic ok_o);
      logic acc;
      acc = 1'b0;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1; acc = arready;
         @(posedge clk); #1;
         if (acc) break;
      end
      arvalid = 1'b0;
      d = rdata; ok_o = acc & rvalid & (rresp == 2'b00);
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      @(posedge clk); #1;
      n_chk++;
      if ({bvalid, rvalid, arready, awready, wready, ping_v, timeout, bresp, rresp, rdata} !==
          {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_outputs: bv=%b rv=%b arr=%b awr=%b pv=%b to=%b rdata=%h",
                  bvalid, rvalid, arready, awready, ping_v, timeout, rdata);
      end
      reset_i = 1'b0;
      sb.push_back(32'd0);
      do_read(28'h8, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL reset_idle0: got %h ok=%0d want %h", rd, ok, exp); end
      // two edges have elapsed since the first read was accepted
      sb.push_back(32'd2);
      do_read(28'h8, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL idle_count: got %h ok=%0d want %h", rd, ok, exp); end
   endtask

   task automatic test_ping_basic;
      do_write(28'h0, 32'hA5A5_0001, bv, pv, ok); exp_count++;
      n_chk++;
      if (!ok || bv !== 1'b1 || pv !== 1'b1 || bresp !== 2'b00) begin
         n_fail++; $display("FAIL ping_resp: ok=%0d bvalid=%b ping_v=%b bresp=%b want 1,1,00", ok, bv, pv, bresp);
      end
      n_chk++;
      if (ping_v !== 1'b0 || bvalid !== 1'b0) begin
         n_fail++; $display("FAIL ping_pulse_len: ping_v=%b bvalid=%b want 0,0", ping_v, bvalid);
      end
      sb.push_back(exp_count); sb.push_back(32'hA5A5_0001);
      do_read(28'h0, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL ping_count1: got %h want %h", rd, exp); end
      do_read(28'h4, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL last_data: got %h want %h", rd, exp); end
      // write to LAST_DATA is ignored and is not a ping
      do_write(28'h4, 32'hDEAD_BEEF, bv, pv, ok);
      n_chk++;
      if (!ok || bv !== 1'b1 || pv !== 1'b0) begin
         n_fail++; $display("FAIL ro_write: ok=%0d bvalid=%b ping_v=%b want 1,1,0", ok, bv, pv);
      end
      // upper address bits are ignored: 0x14 decodes as LAST_DATA
      sb.push_back(32'hA5A5_0001); sb.push_back(exp_count);
      do_read(28'h14, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL ro_last_alias: got %h want %h", rd, exp); end
      do_read(28'h0, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL ro_count: got %h want %h", rd, exp); end
   endtask

   task automatic test_periodic_timeout;
      logic seen;
      seen = 1'b0;
      for (int p = 0; p < 20; p++) begin
         do_write(28'h0, 32'h1000 + p, bv, pv, ok); exp_count++;
         seen |= timeout | ~ok;
         if (p != 19) repeat (48) begin @(posedge clk); #1; seen |= timeout; end
      end
      // last ping accepted at edge T; now at T+1
      repeat (98) begin @(posedge clk); #1; seen |= timeout; end
      n_chk++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL no_early_timeout: timeout seen=%b want 0", seen); end
      @(posedge clk); #1;
      n_chk++;
      if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_edge: timeout=%b want 1 at T+100", timeout); end
      sb.push_back(exp_count);
      do_read(28'h0, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL periodic_count: got %0d want %0d", rd, exp); end
   endtask

   task automatic test_status_clear;
      do_write(28'hC, 32'h0, bv, pv, ok);
      sb.push_back(32'd1);
      do_read(28'hC, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL status_w0: got %h want %h", rd, exp); end
      do_write(28'h0, 32'h55, bv, pv, ok); exp_count++;
      sb.push_back(32'd1);
      do_read(28'hC, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL ping_keeps_timeout: got %h want %h", rd, exp); end
      do_write(28'hC, 32'h1, bv, pv, ok);
      sb.push_back(32'd0);
      do_read(28'hC, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp || timeout !== 1'b0) begin
         n_fail++; $display("FAIL status_clear: got %h timeout=%b want %h", rd, timeout, exp);
      end
      repeat (110) begin @(posedge clk); #1; end
      do_write(28'hC, 32'h1, bv, pv, ok);
      sb.push_back(32'd1);
      do_read(28'hC, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL set_wins: got %h want %h", rd, exp); end
   endtask

   task automatic test_backpressure;
      logic bad;
      int   pulses;
      bad = 1'b0; pulses = 0;
      bready = 1'b0; awaddr = 28'h0; wdata = 32'h1111_0001; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      pulses += ping_v;
      bad |= ~bvalid;
      wdata = 32'h2222_0002;
      repeat (10) begin
         bad |= ~bvalid | awready | wready;
         @(posedge clk); #1;
         pulses += ping_v;
      end
      bad |= ~bvalid | awready;
      n_chk++;
      if (bad !== 1'b0) begin n_fail++; $display("FAIL bp_hold: violation=%b want 0", bad); end
      bready = 1'b1;
      @(posedge clk); #1;
      n_chk++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: bvalid=%b awready=%b want 0,1", bvalid, awready);
      end
      @(posedge clk); #1;
      pulses += ping_v;
      awvalid = 1'b0; wvalid = 1'b0;
      n_chk++;
      if (bvalid !== 1'b1 || pulses != 2) begin
         n_fail++; $display("FAIL bp_second: bvalid=%b pulses=%0d want 1,2", bvalid, pulses);
      end
      @(posedge clk); #1;
      exp_count += 2;
      sb.push_back(32'h2222_0002); sb.push_back(exp_count);
      do_read(28'h4, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL bp_last: got %h want %h", rd, exp); end
      do_read(28'h0, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", rd, exp); end
   endtask

   task automatic test_back_to_back;
      araddr = 28'h0; arvalid = 1'b1; rready = 1'b1;
      awaddr = 28'h0; wdata = 32'h3333_0003; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      sb.push_back(exp_count); exp_count++;
      @(posedge clk); #1;
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      exp = sb.pop_front(); n_chk++;
      if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== exp) begin
         n_fail++; $display("FAIL rw_same_cycle: rdata=%h rv=%b bv=%b want %h,1,1", rdata, rvalid, bvalid, exp);
      end
      @(posedge clk); #1;
      sb.push_back(exp_count);
      do_read(28'h0, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL rw_after: got %0d want %0d", rd, exp); end
   endtask

   task automatic test_reset_midread;
      rready = 1'b0; araddr = 28'h0; arvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_chk++;
      if (rvalid !== 1'b1 || arready !== 1'b0) begin
         n_fail++; $display("FAIL rvalid_hold: rvalid=%b arready=%b want 1,0", rvalid, arready);
      end
      #2 reset_i = 1'b1;
      #1;
      n_chk++;
      if (rvalid !== 1'b0 || arready !== 1'b1 || timeout !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: rvalid=%b arready=%b timeout=%b want 0,1,0", rvalid, arready, timeout);
      end
      @(posedge clk); #1;
      reset_i = 1'b0; rready = 1'b1;
      sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0);
      do_read(28'h8, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL rst_idle: got %h want %h", rd, exp); end
      do_read(28'h0, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL rst_count: got %h want %h", rd, exp); end
      do_read(28'h4, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL rst_last: got %h want %h", rd, exp); end
      do_read(28'hC, rd, ok); exp = sb.pop_front(); n_chk++;
      if (!ok || rd !== exp) begin n_fail++; $display("FAIL rst_status: got %h want %h", rd, exp); end
   endtask

   initial begin
      reset_i = 1'b1;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = 4'hF;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wdata = '0;
      bready = 1'b1; rready = 1'b1;
      test_reset;
      test_ping_basic;
      test_periodic_timeout;
      test_status_clear;
      test_backpressure;
      test_back_to_back;
      test_reset_midread;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL sim_timeout: bench did not complete, elapsed limit reached");
      $fatal(1, "simulation time limit");
   end
endmodule
